// File: rtl/vdp_super_res_renderer.sv
// Super-res VRAM line renderer: fetch lines read VRAM, replay lines reuse a line buffer.
// Optional RGB565 unpack/expand path is built when SUPER_RES_RGB565_EN is defined.
module vdp_super_res_renderer #(
  parameter int WIDTH    = 64,
  parameter int HEIGHT   = 64,
  parameter int V_REPEAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        super_high_res,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  input  logic [1:0]  dot_state,
  input  logic        pal_mode,
  input  logic        pix_fmt,
  input  logic [31:0] vrm_32,
  output logic [16:0] high_res_vram_addr,
  output logic [7:0]  high_res_red,
  output logic [7:0]  high_res_green,
  output logic [7:0]  high_res_blue
);
  localparam int SW    = $clog2(WIDTH);
  localparam int DEPTH = 1 << SW;

  localparam logic [10:0] H_END   = 11'(WIDTH * 4);
  localparam logic [10:0] V_END   = 11'(HEIGHT * V_REPEAT);
  localparam logic [9:0]  VR_MASK = 10'(V_REPEAT - 1);

  localparam logic [9:0]  LAST_NTSC = 10'd261;
  localparam logic [9:0]  LAST_PAL  = 10'd312;

  localparam logic [10:0] PF_START = 11'd722;
  localparam logic [10:0] PF_CAP   = 11'd725;
  localparam logic [10:0] PF_ADDR  = 11'd726;

  localparam logic [1:0] DL = 2'd0;
  localparam logic [1:0] DR = 2'd1;
  localparam logic [1:0] AP = 2'd3;

`ifdef SUPER_RES_RGB565_EN
  localparam int FW = 32;
`else
  localparam int FW = 24;
`endif

  logic [SW-1:0] slot;
  logic [FW-1:0] fetch;
  logic [23:0]   line_buffer [DEPTH];
  logic          fetch_q;
  logic          primed;
  logic          fmt_q;
  logic [23:0]   pix;
  logic [23:0]   cur;
  logic          word_step;

  logic last_line;
  logic visible;
  logic fetch_line;
  logic pf_hit;
  logic slot_clr;
  logic pf_cap;
  logic pf_addr;
  logic act;
  logic dl;
  logic dr;
  logic ap;
  logic clr;

  assign clr        = reset || !super_high_res;
  assign last_line  = cy == (pal_mode ? LAST_PAL : LAST_NTSC);
  assign visible    = (cx < H_END) && ({1'b0, cy} < V_END);
  assign fetch_line = (cy & VR_MASK) == 10'd0;
  assign pf_hit     = last_line && (cx >= PF_START) && (cx <= PF_ADDR);
  assign slot_clr   = cx == PF_START;
  assign pf_cap     = last_line && (cx == PF_CAP);
  assign pf_addr    = last_line && (cx == PF_ADDR);
  assign act        = visible && !pf_hit && !slot_clr;
  assign dl         = act && (dot_state == DL);
  assign dr         = act && (dot_state == DR) && fetch_q && word_step;
  assign ap         = act && (dot_state == AP) && fetch_q && word_step;

`ifdef SUPER_RES_RGB565_EN
  logic [15:0] half;

  assign half      = slot[0] ? fetch[31:16] : fetch[15:0];
  assign word_step = !fmt_q || !slot[0];

  always_comb begin
    pix = fetch[23:0];
    if (fmt_q)
      pix = {half[15:11], half[15:13],
             half[10:5],  half[10:9],
             half[4:0],   half[4:2]};
  end

  // Format only changes at the frame prefetch so a frame never mixes formats.
  always_ff @(posedge clk) begin
    if (clr)
      fmt_q <= 1'b0;
    else if (slot_clr && last_line)
      fmt_q <= pix_fmt;
  end
`else
  logic unused_in;

  assign unused_in = ^{pix_fmt, vrm_32[31:24]};
  assign fmt_q     = 1'b0;
  assign word_step = 1'b1;
  assign pix       = fetch;
`endif

  assign cur = fetch_line ? pix : line_buffer[slot];

  always_ff @(posedge clk) begin
    if (clr) begin
      high_res_vram_addr <= '0;
      slot               <= '0;
      fetch              <= '0;
      fetch_q            <= 1'b0;
      primed             <= 1'b0;
      high_res_red       <= '0;
      high_res_green     <= '0;
      high_res_blue      <= '0;
    end else begin
      fetch_q <= fetch_line;
      if (!visible)
        {high_res_red, high_res_green, high_res_blue} <= '0;
      else if (dl)
        {high_res_red, high_res_green, high_res_blue} <= primed ? cur : 24'd0;
      unique case (1'b1)
        slot_clr: begin
          slot <= '0;
          if (last_line)
            high_res_vram_addr <= '0;
        end
        pf_cap:  fetch <= vrm_32[FW-1:0];
        pf_addr: begin
          high_res_vram_addr <= 17'd2;
          primed             <= 1'b1;
        end
        dl:      slot <= slot + 1'b1;
        dr:      fetch <= vrm_32[FW-1:0];
        ap:      high_res_vram_addr <= high_res_vram_addr + 17'd2;
        default: ;
      endcase
    end
  end

  // Line buffer survives reset so replay data is never lost to a glitch.
  always_ff @(posedge clk) begin
    if (!clr && dl && fetch_line)
      line_buffer[slot] <= pix;
  end
endmodule

// File: doc/vdp_super_res_renderer.md
VDP_SUPER_RES_RENDERER -- requirements
Module: vdp_super_res_renderer

Interface
REQ-001 Parameter WIDTH, default 64: source pixels per line, range 2..256, even.
REQ-002 Parameter HEIGHT, default 64: source lines per frame.
REQ-003 Parameter V_REPEAT, default 4: output lines per source line; allowed values 1, 2, 4, 8.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high.
REQ-006 Port super_high_res, input, 1: block enable; low acts as synchronous reset.
REQ-007 Port cx, input, 11: horizontal clock position.
REQ-008 Port cy, input, 10: vertical line position.
REQ-009 Port dot_state, input, 2: pixel phase (0 = DL, 1 = DR, 2 = FS, 3 = AP).
REQ-010 Port pal_mode, input, 1: selects FRAME_HEIGHT from custom_timings.
REQ-011 Port pix_fmt, input, 1: 0 = RGB888 (one pixel per word, bits [23:0]); 1 = RGB565 (two pixels per word).
REQ-012 Port vrm_32, input, 32: VRAM read data.
REQ-013 Port high_res_vram_addr, output, 17: VRAM word address, in 16-bit units.
REQ-014 Ports high_res_red, high_res_green, high_res_blue, output, 8 each: pixel colour.

Function
REQ-015 last_line SHALL be true when cy == FRAME_HEIGHT(pal_mode) - 1.
REQ-016 Horizontal window SHALL be cx in [0, WIDTH*4); vertical window SHALL be cy in [0, HEIGHT*V_REPEAT); visible means inside both windows.
REQ-017 Outside the visible area, colour outputs SHALL be 0; address, slot index and line buffer SHALL hold.
REQ-018 A line is a fetch line when cy mod V_REPEAT == 0; any other line is a replay line.
REQ-019 DL on a fetch line: output the current pixel, write it to line_buffer[slot], then slot <= slot + 1.
REQ-020 DL on a replay line: output line_buffer[slot], then slot <= slot + 1.
REQ-021 RGB888 fetch line: at DR, capture vrm_32[23:0] as the next pixel; at AP, address <= address + 2.
REQ-022 RGB565 fetch line: DR and AP SHALL act only after odd slots; the low halfword is pixel 2n and the high halfword is pixel 2n+1.
REQ-023 RGB565 expansion SHALL be R = {r5, r5[4:2]}, G = {g6, g6[5:4]}, B = {b5, b5[4:2]}.
REQ-024 Frame prefetch on last_line:
  - cx == 722: address <= 0, slot <= 0.
  - cx == 725: capture vrm_32.
  - cx == 726: address <= 2.
REQ-025 On every other line, cx == 722 SHALL reset slot to 0 only.
REQ-026 pix_fmt SHALL be latched at cx == 722 of last_line; changes mid-frame SHALL have no effect until the next frame.
REQ-027 Address arithmetic SHALL be modulo 2^17; slot index width SHALL be clog2(WIDTH).
REQ-028 Colour output latency SHALL be 1 clock after the DL edge.
REQ-029 When prefetch (cx 722..726) coincides with the visible window, prefetch SHALL take priority.

Reset
REQ-030 When reset or ~super_high_res is high at a clock edge, the following SHALL be cleared to 0 on that edge: address, colour outputs, slot index, fetch register, latched pix_fmt, fetch-line flag.
REQ-031 Line buffer contents SHALL NOT be cleared by reset.
REQ-032 If reset is asserted mid-line, the block SHALL output black until the next frame prefetch completes.

Configuration
REQ-033 Macro SUPER_RES_RGB565_EN defined: pix_fmt is honoured and the RGB565 unpack/expand path is present.
REQ-034 Macro SUPER_RES_RGB565_EN undefined: pix_fmt is ignored, operation is RGB888 only, and no unpack logic is synthesised.

Verification
REQ-035 Scenario A: RGB888, vrm_32 = 0x00FF8040 at prefetch -> first DL of cy 0 gives R = FF, G = 80, B = 40; address = 2, then 4 after the first AP.
REQ-036 Scenario B: V_REPEAT = 4, fetch line cy 0 with pixel k = k -> cy 1..3 replay identical pixels; address unchanged during cy 1..3; cy 4 fetches again.
REQ-037 Scenario C: RGB565, vrm_32 = 0xF800_001F -> pixel 0 = (00, 00, FF), pixel 1 = (FF, 00, 00); address advances once per two pixels.
REQ-038 Scenario D: pix_fmt toggled at cy 10 -> format unchanged until the next frame.
REQ-039 Scenario E: reset asserted at cx 100 -> outputs and address are 0 on the next edge; normal output resumes after the following last_line prefetch.
REQ-040 Scenario F: SUPER_RES_RGB565_EN undefined with pix_fmt = 1 -> output is identical to Scenario A.
